vga_scanout: RTL and testbench

- Read side of the 1-bit game framebuffer.
- Generates 640x480@60 VGA timing from the 50 MHz clock.
- Fetches one pixel per pixel period from a synchronous frame memory and drives the DE1-SoC VGA DAC pins.
- Exports a vblank level and a frame_start pulse so game/draw logic can update the frame memory between frames without tearing.

---
 rtl/vga_scanout.sv | 156 +++++++++++++++
 tb/tb_vga_scanout.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: read side of the 1-bit game framebuffer, 640x480@60 VGA timing from a 50 MHz clock.
// Counters -> address -> memory -> pixel -> pins is a fixed four-clock pipeline with matched control delay.
module vga_scanout #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
   parameter logic [23:0] BG_COLOR = 24'h000000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        rd_en,
   output logic [18:0] rd_addr,
   input  logic        rd_data,
   output logic        vblank,
   output logic        frame_start,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        VGA_CLK,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic          rst_meta, rst_sync;
   logic          phase;
   logic          pix_en;
   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          active, hsync, vsync;
   logic [18:0]   addr_calc;
   logic          hs1, vs1;
   logic          act2, hs2, vs2;
   logic          act3, hs3, vs3, pix3;

   // Reset asserts asynchronously but is released through two flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta <= 1'b0;
         rst_sync <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_sync <= rst_meta;
      end
   end

   assign pix_en     = phase;
   assign VGA_CLK    = phase;
   assign VGA_SYNC_N = 1'b0;

   always_comb begin
      active = (h < H_VIS) && (v < V_VIS);
      hsync  = (h >= HS_START) && (h < HS_END);
      vsync  = (v >= VS_START) && (v < VS_END);
   end

   generate
      if (H_ACTIVE == 640) begin : g_addr_shift
         always_comb addr_calc = (19'(v) << 9) + (19'(v) << 7) + 19'(h);
      end else begin : g_addr_mul
         always_comb addr_calc = 19'(v) * 19'(H_ACTIVE) + 19'(h);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         phase <= 1'b0;
         h     <= '0;
         v     <= '0;
      end else begin
         phase <= ~phase;
         if (pix_en) begin
            if (h == H_LAST) begin
               h <= '0;
               v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
               h <= h + 1'b1;
            end
         end
      end
   end

   // Stages 1-3 run every clk; the counters only move every other clk,
   // so each stage holds one pixel for two clocks and the output stage
   // picks it up on the pix_en edge four clocks after the counters.
   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         rd_en       <= 1'b0;
         rd_addr     <= '0;
         hs1         <= 1'b0;
         vs1         <= 1'b0;
         act2        <= 1'b0;
         hs2         <= 1'b0;
         vs2         <= 1'b0;
         act3        <= 1'b0;
         hs3         <= 1'b0;
         vs3         <= 1'b0;
         pix3        <= 1'b0;
         vblank      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         rd_en       <= active;
         rd_addr     <= active ? addr_calc : '0;
         hs1         <= hsync;
         vs1         <= vsync;
         act2        <= rd_en;
         hs2         <= hs1;
         vs2         <= vs1;
         act3        <= act2;
         hs3         <= hs2;
         vs3         <= vs2;
         pix3        <= rd_data & act2;
         vblank      <= (v >= V_VIS);
         frame_start <= (v == V_VIS) && !vblank;
      end
   end

   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         {VGA_R, VGA_G, VGA_B} <= '0;
      end else if (pix_en) begin
         VGA_HS      <= ~hs3;
         VGA_VS      <= ~vs3;
         VGA_BLANK_N <= act3;
         if (!act3)
            {VGA_R, VGA_G, VGA_B} <= '0;
         else
            {VGA_R, VGA_G, VGA_B} <= pix3 ? FG_COLOR : BG_COLOR;
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: reduced-geometry and default-geometry scanout checked clock by clock
// against an arithmetic position/time model of the VGA frame.
module tb_vga_scanout;

   localparam logic [23:0] S_FG = 24'h12A5C3;
   localparam logic [23:0] S_BG = 24'h3C0011;
   localparam int S_FRAME_CLK = 2 * 23 * 11;

   logic clk;
   logic reset_n;
   logic all_ones;
   logic small_mem [0:95];
   int   n;
   int   checks;
   int   failures;

   logic        rd_en_s, rd_data_s, vblank_s, fs_s;
   logic [18:0] rd_addr_s;
   logic [7:0]  r_s, g_s, b_s;
   logic        vclk_s, hs_s, vs_s, blank_n_s, sync_n_s;

   logic        rd_en_d, rd_data_d, vblank_d, fs_d;
   logic [18:0] rd_addr_d;
   logic [7:0]  r_d, g_d, b_d;
   logic        vclk_d, hs_d, vs_d, blank_n_d, sync_n_d;

   vga_scanout #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
      .FG_COLOR(S_FG), .BG_COLOR(S_BG)
   ) dut_small (
      .clk(clk), .reset_n(reset_n),
      .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
      .vblank(vblank_s), .frame_start(fs_s),
      .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s),
      .VGA_CLK(vclk_s), .VGA_HS(hs_s), .VGA_VS(vs_s),
      .VGA_BLANK_N(blank_n_s), .VGA_SYNC_N(sync_n_s)
   );

   vga_scanout dut_full (
      .clk(clk), .reset_n(reset_n),
      .rd_en(rd_en_d), .rd_addr(rd_addr_d), .rd_data(rd_data_d),
      .vblank(vblank_d), .frame_start(fs_d),
      .VGA_R(r_d), .VGA_G(g_d), .VGA_B(b_d),
      .VGA_CLK(vclk_d), .VGA_HS(hs_d), .VGA_VS(vs_d),
      .VGA_BLANK_N(blank_n_d), .VGA_SYNC_N(sync_n_d)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic pix(input int inst, input int a);
      if (all_ones) return 1'b1;
      if (inst == 0) return small_mem[a];
      return a[0] ^ a[10];
   endfunction

   // Synchronous frame memories: one-clock read latency, garbage when not read.
   always @(posedge clk) begin
      rd_data_s <= rd_en_s ? pix(0, int'(rd_addr_s)) : 1'($urandom);
      rd_data_d <= rd_en_d ? pix(1, int'(rd_addr_d)) : 1'($urandom);
   end

   // e = clocks since the design left reset; position k is on the counters
   // from clock 2k, addressed one clock later, on the pins four clocks later.
   function automatic void model(input int inst, input int e,
                                 output logic [31:0] x_rd, output logic [31:0] x_frm,
                                 output logic [31:0] x_vga);
      int ha, hf, hs, va, vf, vs, ht, vt, k, h, v;
      logic [23:0] fg, bg;
      logic vis;
      if (inst == 0) begin
         ha = 16;  hf = 2;  hs = 3;  ht = 23;
         va = 6;   vf = 1;  vs = 2;  vt = 11;
         fg = S_FG; bg = S_BG;
      end else begin
         ha = 640; hf = 16; hs = 96; ht = 800;
         va = 480; vf = 10; vs = 2;  vt = 525;
         fg = 24'hFFFFFF; bg = 24'h000000;
      end
      x_rd  = '0;
      x_frm = '0;
      x_vga = 32'h0C00_0000;
      if (e > 0) begin
         k = (e - 1) / 2;
         h = k % ht;
         v = (k / ht) % vt;
         if (h < ha && v < va) x_rd = {12'b0, 1'b1, 19'(v * ha + h)};
         x_frm[1] = (v >= va);
         x_frm[0] = (e % 2 == 1) && (h == 0) && (v == va);
         x_vga[28] = (e % 2 == 1);
      end
      if (e >= 4) begin
         k = (e - 4) / 2;
         h = k % ht;
         v = (k / ht) % vt;
         vis = (h < ha) && (v < va);
         x_vga[27] = !(h >= ha + hf && h < ha + hf + hs);
         x_vga[26] = !(v >= va + vf && v < va + vf + vs);
         x_vga[25] = vis;
         x_vga[23:0] = vis ? (pix(inst, v * ha + h) ? fg : bg) : 24'h0;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s e=%0d observed=%h expected=%h", tag, n - 2, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] x_rd, x_frm, x_vga;
      model(0, n - 2, x_rd, x_frm, x_vga);
      chk("small_rd",  {12'b0, rd_en_s, rd_addr_s}, x_rd);
      chk("small_frm", {30'b0, vblank_s, fs_s}, x_frm);
      chk("small_vga", {3'b0, vclk_s, hs_s, vs_s, blank_n_s, sync_n_s, r_s, g_s, b_s}, x_vga);
      model(1, n - 2, x_rd, x_frm, x_vga);
      chk("full_rd",  {12'b0, rd_en_d, rd_addr_d}, x_rd);
      chk("full_frm", {30'b0, vblank_d, fs_d}, x_frm);
      chk("full_vga", {3'b0, vclk_d, hs_d, vs_d, blank_n_d, sync_n_d, r_d, g_d, b_d}, x_vga);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (reset_n) n++;
      check_all();
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic async_reset(input int hold);
      #2;
      reset_n = 1'b0;
      n = 0;
      #1;
      check_all();
      for (int i = 0; i < hold; i++) step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      n        = 0;
      reset_n  = 1'b0;
      all_ones = 1'b0;
      for (int i = 0; i < 96; i++) small_mem[i] = 1'($urandom);

      for (int i = 0; i < 10; i++) step();
      release_reset();
      for (int i = 0; i < 3 * S_FRAME_CLK + 40; i++) step();

      // Mid-frame reset at a random point, then full frames from (0,0).
      for (int i = 0; i < int'($urandom_range(150, 400)); i++) step();
      async_reset(int'($urandom_range(3, 9)));
      for (int i = 0; i < 96; i++) small_mem[i] = 1'($urandom);
      release_reset();
      for (int i = 0; i < 2 * S_FRAME_CLK + 20; i++) step();

      // Memory returns 1 everywhere: porches and sync must still be black.
      async_reset(4);
      all_ones = 1'b1;
      release_reset();
      for (int i = 0; i < 2 * S_FRAME_CLK + 20; i++) step();

      // Default geometry over the first 22 lines with the a[0]^a[10] pattern.
      async_reset(5);
      all_ones = 1'b0;
      release_reset();
      for (int i = 0; i < 22 * 1600 + 10; i++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
